// File: rtl/kernel_cc_pkg.sv
// Shared kernel_cc definitions: start-consumer FSM encoding and start-token kinds.
package kernel_cc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_HALT   = 2'd3
  } cc_state_e;

  // bit0 of a start token selects whether the downstream process is launched
  typedef enum logic {
    TOKEN_SKIP = 1'b0,
    TOKEN_RUN  = 1'b1
  } token_kind_e;

  function automatic logic token_is_run(input logic bit0);
    return token_kind_e'(bit0) == TOKEN_RUN;
  endfunction

endpackage

// File: rtl/kernel_cc_start_consumer_wdog.sv
// RUN-duration watchdog: counts consecutive RUN cycles and raises a sticky timeout flag.
module kernel_cc_start_consumer_wdog #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expire,
  output logic timeout
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic ENABLED = (TIMEOUT_CYCLES != 0);

  logic [W-1:0] count;

  // expire fires in the TIMEOUT_CYCLES-th consecutive tick without a clear
  assign expire = ENABLED && tick && (count == LAST);

  // RUN-cycle counter
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

  // sticky timeout flag, released only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout <= 1'b0;
    end else if (expire) begin
      timeout <= 1'b1;
    end else begin
      timeout <= timeout;
    end
  end

endmodule

// File: rtl/kernel_cc_start_consumer_ctrl.sv
// Start-token consumer: pops tokens from a start FIFO and drives a downstream ap_ctrl process.
module kernel_cc_start_consumer_ctrl
  import kernel_cc_pkg::*;
#(
  parameter int DATA_WIDTH     = 1,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_empty_n,
  output logic                  start_read,
  input  logic [DATA_WIDTH-1:0] start_dout,
  output logic                  proc_ap_start,
  input  logic                  proc_ap_ready,
  input  logic                  proc_ap_done,
  input  logic                  proc_ap_idle,
  output logic                  ctrl_idle,
  output logic                  ctrl_done,
  output logic [CNT_WIDTH-1:0]  done_count,
  output logic [CNT_WIDTH-1:0]  skip_count,
  output logic                  err_timeout
);

  cc_state_e state, state_next;
  logic      pop, finish, token_run, wd_tick, wd_expire;
  logic      token_unused;

  // only bit0 carries meaning; the remaining token bits are accepted and dropped
  assign token_unused = ^start_dout;
  assign token_run    = token_is_run(start_dout[0]);
  assign wd_tick      = (state == ST_RUN) && !proc_ap_done;

  // next-state: pop decisions, launch, completion and watchdog halt
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE:   pop = start_empty_n && !err_timeout;
      ST_LAUNCH: begin
        if (proc_ap_ready && proc_ap_done) begin
          finish = 1'b1;
        end else if (proc_ap_ready) begin
          state_next = ST_RUN;
        end else begin
          state_next = ST_LAUNCH;
        end
      end
      ST_RUN: begin
        if (proc_ap_done) begin
          finish = 1'b1;
        end else if (wd_expire) begin
          state_next = ST_HALT;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_HALT:   state_next = ST_HALT;
      default:   state_next = ST_IDLE;
    endcase
    // a completion may immediately consume the next queued token
    if (finish) begin
      state_next = ST_IDLE;
      pop        = start_empty_n;
    end else begin
      pop = pop;
    end
    if (pop && token_run) begin
      state_next = ST_LAUNCH;
    end else begin
      state_next = state_next;
    end
  end

  assign start_read    = pop && !reset;
  assign ctrl_done     = finish && !reset;
  assign proc_ap_start = (state == ST_LAUNCH);
  assign ctrl_idle     = (state == ST_IDLE) && !start_empty_n && proc_ap_idle;

  // state register and wrapping event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      done_count <= '0;
      skip_count <= '0;
    end else begin
      state <= state_next;
      if (finish) begin
        done_count <= done_count + CNT_WIDTH'(1);
      end
      if (pop && !token_run) begin
        skip_count <= skip_count + CNT_WIDTH'(1);
      end
    end
  end

  kernel_cc_start_consumer_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (!wd_tick),
    .tick    (wd_tick),
    .expire  (wd_expire),
    .timeout (err_timeout)
  );

endmodule

// File: tb/tb_kernel_cc_start_consumer_ctrl.sv
// Randomised scoreboard bench for kernel_cc_start_consumer_ctrl with directed corner scenarios.
module tb_kernel_cc_start_consumer_ctrl;

  localparam int DW = 2;
  localparam int CW = 4;
  localparam int TO = 8;
  localparam int NEVER = 100000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_empty_n = 1'b0;
  logic          start_read;
  logic [DW-1:0] start_dout = '0;
  logic          proc_ap_start;
  logic          proc_ap_ready = 1'b0;
  logic          proc_ap_done = 1'b0;
  logic          proc_ap_idle = 1'b1;
  logic          ctrl_idle, ctrl_done, err_timeout;
  logic [CW-1:0] done_count, skip_count;

  kernel_cc_start_consumer_ctrl #(
    .DATA_WIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .start_empty_n(start_empty_n), .start_read(start_read), .start_dout(start_dout),
    .proc_ap_start(proc_ap_start), .proc_ap_ready(proc_ap_ready),
    .proc_ap_done(proc_ap_done), .proc_ap_idle(proc_ap_idle),
    .ctrl_idle(ctrl_idle), .ctrl_done(ctrl_done),
    .done_count(done_count), .skip_count(skip_count), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_err = 0;
  logic [DW-1:0] fifo_q[$];   // tokens visible to the DUT
  logic [DW-1:0] exp_q[$];    // scoreboard copy of issued tokens
  int  pending = 0, exp_done = 0, exp_skip = 0;
  bit  mon_en = 1'b0, noise = 1'b0;
  int  fix_r = 0, fix_d = 0;
  int  cyc = 0, n_reads = 0, n_start = 0, n_dones = 0, n_read_done = 0, n_done_launch = 0;
  int  last_read_cyc = 0, last_done_cyc = 0;
  int  s_reads, s_start, s_dones, s_read_done, s_done_launch;
  logic [DW-1:0] mon_tok;

  task automatic check(input string name, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic push_token(input logic [DW-1:0] t);
    fifo_q.push_back(t);
    exp_q.push_back(t);
    start_empty_n = 1'b1;
    start_dout    = fifo_q[0];
  endtask

  task automatic snap();
    #1;
    s_reads = n_reads; s_start = n_start; s_dones = n_dones;
    s_read_done = n_read_done; s_done_launch = n_done_launch;
  endtask

  task automatic do_reset();
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
  endtask

  task automatic wait_for(input bit want_done, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      hit = want_done ? ctrl_done : start_read;
    end
    if (!hit) check(name, 0, 1);
  endtask

  // FIFO and downstream-process models, updated just after each rising edge
  int  rdelay = 0, ddelay = 0, launch_i = 0, since = 0;
  bit  busy = 1'b0, rd = 1'b0;
  always begin
    @(negedge clk);
    rd = start_read;
    @(posedge clk);
    #1;
    if (rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
    start_empty_n = (fifo_q.size() > 0);
    start_dout    = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    proc_ap_ready = 1'b0;
    proc_ap_done  = 1'b0;
    if (reset) begin
      busy = 1'b0; launch_i = 0;
    end else begin
      if (busy) begin
        since++;
        if (since == ddelay) begin proc_ap_done = 1'b1; busy = 1'b0; end
      end
      if (proc_ap_start) begin
        if (launch_i == 0) begin
          rdelay = (fix_r < 0) ? int'($urandom_range(0, 3)) : fix_r;
          ddelay = (fix_d < 0) ? int'($urandom_range(0, 5)) : fix_d;
        end
        if (launch_i == rdelay) begin
          proc_ap_ready = 1'b1; launch_i = 0;
          if (ddelay == 0) proc_ap_done = 1'b1;
          else begin busy = 1'b1; since = 0; end
        end else launch_i++;
      end else if (!busy && !proc_ap_done && noise) begin
        proc_ap_done = ($urandom_range(0, 3) == 0);
      end
    end
    proc_ap_idle = !busy && !proc_ap_start;
  end

  // scoreboard monitor: consumes issued tokens as the DUT pops them
  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      check("done_count", int'(done_count), exp_done % (1 << CW));
      check("skip_count", int'(skip_count), exp_skip % (1 << CW));
      check("ctrl_idle", int'(ctrl_idle), int'(pending == 0 && !start_empty_n && proc_ap_idle));
      if (proc_ap_start) begin
        n_start++;
        check("start_has_task", int'(pending > 0), 1);
      end
      if (reset) check("reset_gating", int'(start_read | ctrl_done), 0);
      if (ctrl_done) begin
        n_dones++; last_done_cyc = cyc;
        if (proc_ap_start) n_done_launch++;
        if (start_read) n_read_done++;
        check("done_has_task", int'(pending > 0 && proc_ap_done), 1);
        if (pending > 0) pending--;
        exp_done++;
      end
      if (start_read) begin
        n_reads++; last_read_cyc = cyc;
        check("read_nonempty", int'(start_empty_n && exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_tok = exp_q.pop_front();
          if (mon_tok[0]) pending++;
          else exp_skip++;
        end
      end
      if (reset) begin pending = 0; exp_done = 0; exp_skip = 0; end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  int s0;
  initial begin
    repeat (3) @(posedge clk);
    #2 reset = 1'b0; mon_en = 1'b1;
    @(negedge clk); #1;
    check("rst_done_count", int'(done_count), 0);
    check("rst_skip_count", int'(skip_count), 0);
    check("rst_err", int'(err_timeout), 0);
    check("rst_start", int'(proc_ap_start), 0);
    check("rst_idle", int'(ctrl_idle), 1);

    // single token: ready after 2 cycles, done 5 cycles later
    fix_r = 2; fix_d = 5; snap();
    @(posedge clk); #2 push_token(2'b01);
    wait_for(1'b0, "t1_read_wait"); wait_for(1'b1, "t1_done_wait");
    @(negedge clk); #1;
    check("t1_reads", n_reads - s_reads, 1);
    check("t1_start_cycles", n_start - s_start, 3);
    check("t1_dones", n_dones - s_dones, 1);
    check("t1_latency", last_done_cyc - last_read_cyc, 8);
    check("t1_done_count", int'(done_count), 1);

    // three queued tokens, ready and done one cycle apart
    fix_r = 0; fix_d = 1; do_reset(); snap();
    @(posedge clk); #2 push_token(2'b01); push_token(2'b11); push_token(2'b01);
    wait_for(1'b0, "t2_read_wait"); #1 s0 = last_read_cyc;
    for (int k = 0; k < 3; k++) wait_for(1'b1, "t2_done_wait");
    @(negedge clk); #1;
    check("t2_reads", n_reads - s_reads, 3);
    check("t2_read_with_done", n_read_done - s_read_done, 2);
    check("t2_span", last_done_cyc - s0, 6);
    check("t2_done_count", int'(done_count), 3);

    // skip token followed by a run token
    fix_r = 1; fix_d = 2; do_reset(); snap();
    @(posedge clk); #2 push_token(2'b10); push_token(2'b01);
    wait_for(1'b1, "t3_done_wait");
    @(negedge clk); #1;
    check("t3_skip_count", int'(skip_count), 1);
    check("t3_done_count", int'(done_count), 1);
    check("t3_start_cycles", n_start - s_start, 2);
    check("t3_reads", n_reads - s_reads, 2);

    // ready and done in the same cycle
    fix_r = 1; fix_d = 0; do_reset(); snap();
    @(posedge clk); #2 push_token(2'b01);
    wait_for(1'b0, "t4_read_wait"); wait_for(1'b1, "t4_done_wait");
    @(negedge clk); #1;
    check("t4_done_in_launch", n_done_launch - s_done_launch, 1);
    check("t4_latency", last_done_cyc - last_read_cyc, 2);
    check("t4_done_count", int'(done_count), 1);

    // reset in the cycle the task completes with another token waiting
    fix_r = 0; fix_d = 3; do_reset();
    @(posedge clk); #2 push_token(2'b01); push_token(2'b11);
    wait_for(1'b0, "t6_read_wait");
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk); #1;
    s0 = fifo_q.size();
    check("t6_read_gated", int'(start_read), 0);
    check("t6_done_gated", int'(ctrl_done), 0);
    @(posedge clk); #2 reset = 1'b0;
    check("t6_fifo_level", int'(fifo_q.size()), 1);
    check("t6_fifo_kept", int'(fifo_q.size()), s0);
    check("t6_done_count", int'(done_count), 0);
    check("t6_start", int'(proc_ap_start), 0);
    check("t6_err", int'(err_timeout), 0);
    wait_for(1'b1, "t6_done_wait");
    @(negedge clk); #1;
    check("t6_done_after", int'(done_count), 1);

    // watchdog: no done ever arrives
    fix_r = 0; fix_d = NEVER; do_reset();
    @(posedge clk); #2 push_token(2'b01);
    wait_for(1'b0, "t5_read_wait");
    repeat (9) @(negedge clk);
    check("t5_err_before", int'(err_timeout), 0);
    @(negedge clk);
    check("t5_err_set", int'(err_timeout), 1);
    snap();
    @(posedge clk); #2 push_token(2'b01); push_token(2'b11);
    repeat (12) @(negedge clk); #1;
    check("t5_halt_reads", n_reads - s_reads, 0);
    check("t5_halt_starts", n_start - s_start, 0);
    check("t5_err_sticky", int'(err_timeout), 1);

    // randomised traffic with spurious dones and one mid-stream reset
    fix_r = -1; fix_d = -1; noise = 1'b1; do_reset(); snap();
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #2;
      reset = (i == 300);
      if ($urandom_range(0, 5) == 0) push_token(DW'($urandom));
    end
    @(posedge clk); #2 reset = 1'b0;
    repeat (200) @(posedge clk);
    #2 noise = 1'b0;
    check("rand_drained", int'(fifo_q.size()), 0);
    check("rand_activity", int'(n_dones - s_dones > 5), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
